// File: rtl/mem_bus_if.sv
// Request/response bus between the core datapath and the memory-side responder.
// The master issues one request at a time and waits for the single response pulse.
interface mem_bus_if;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_bus_responder.sv
// Memory-side responder for the core's unified instruction/data bus.
// Serves word accesses to an on-chip RAM and a two-register GPIO window,
// inserting WAIT_CYCLES wait states and answering every request with a
// single-cycle response pulse.
module mem_bus_responder #(
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] IO_BASE     = 32'h1001_0000
) (
  input  logic           clk_i,
  input  logic           reset_i,
  mem_bus_if.slave       bus,
  input  logic [7:0]     gpio_in_i,
  output logic [7:0]     gpio_out_o
);

  localparam int unsigned AW        = $clog2(MEM_DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(MEM_DEPTH * 4);
  localparam logic [31:0] IO_IN     = IO_BASE + 32'd4;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        wr_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        resp_valid_q;
  logic [7:0]  gpio_q;

  logic [31:0] mem_q [MEM_DEPTH];

  logic [AW-1:0] idx;
  logic [31:0]   rdata_d;
  logic          err_d;
  logic [7:0]    gpio_d;
  logic          ram_we;

  assign idx = addr_q[AW+1:2];

  // Decode the latched request into read data, error flag and side effects.
  always_comb begin
    rdata_d = '0;
    err_d   = 1'b0;
    gpio_d  = gpio_q;
    ram_we  = 1'b0;
    if (addr_q[1:0] != 2'b00) begin
      err_d = 1'b1;
    end else if (addr_q < RAM_BYTES) begin
      if (wr_q) ram_we = 1'b1;
      else      rdata_d = mem_q[idx];
    end else if (addr_q == IO_BASE) begin
      if (wr_q) gpio_d = wdata_q[7:0];
      else      rdata_d = {24'b0, gpio_q};
    end else if (addr_q == IO_IN) begin
      if (wr_q) err_d = 1'b1;
      else      rdata_d = {24'b0, gpio_in_i};
    end else begin
      err_d = 1'b1;
    end
  end

  // Request/wait/access/response sequencer; response fields are registered
  // and cleared again when leaving RESP so they read zero outside the pulse.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      gpio_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          resp_valid_q <= 1'b0;
          if (bus.req_valid) begin
            wr_q    <= bus.req_write;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            cnt_q   <= WAIT_INIT;
            state_q <= (WAIT_CYCLES != 0) ? S_WAIT : S_ACCESS;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q <= 4'd1) state_q <= S_ACCESS;
        end
        S_ACCESS: begin
          rdata_q      <= rdata_d;
          err_q        <= err_d;
          gpio_q       <= gpio_d;
          resp_valid_q <= 1'b1;
          state_q      <= S_RESP;
        end
        S_RESP: begin
          resp_valid_q <= 1'b0;
          rdata_q      <= '0;
          err_q        <= 1'b0;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // RAM write port; contents survive reset, and a write only lands on the
  // ACCESS edge so an aborted transaction leaves memory untouched.
  always_ff @(posedge clk_i) begin
    if (state_q == S_ACCESS && ram_we) mem_q[idx] <= wdata_q;
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign gpio_out_o     = gpio_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: directed scenarios plus randomized traffic
// against a behavioural memory/GPIO model.
module tb_mem_bus_responder;
  localparam logic [31:0] IO_BASE = 32'h1001_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, rst0;
  logic [7:0] gin, gout, gin0, gout0;

  mem_bus_if bus ();
  mem_bus_if bus0 ();

  mem_bus_responder #(.MEM_DEPTH(256), .WAIT_CYCLES(2), .IO_BASE(IO_BASE)) dut (
    .clk_i(clk), .reset_i(rst), .bus(bus), .gpio_in_i(gin), .gpio_out_o(gout));

  mem_bus_responder #(.MEM_DEPTH(256), .WAIT_CYCLES(0), .IO_BASE(IO_BASE)) dut0 (
    .clk_i(clk), .reset_i(rst0), .bus(bus0), .gpio_in_i(gin0), .gpio_out_o(gout0));

  int checks = 0;
  int failures = 0;

  logic [31:0] mdl_mem [256];
  logic [7:0]  mdl_gpio;

  // Behavioural model of one access, applied at response time.
  function automatic void model(input logic w, input logic [31:0] a, input logic [31:0] d,
                                input logic [7:0] gi, output logic [31:0] rd, output logic e);
    rd = 32'h0;
    e  = 1'b0;
    if (a % 4 != 0) e = 1'b1;
    else if (a < 32'd1024) begin
      if (w) mdl_mem[int'(a / 4)] = d;
      else   rd = mdl_mem[int'(a / 4)];
    end else if (a == IO_BASE) begin
      if (w) mdl_gpio = d[7:0];
      else   rd = {24'h0, mdl_gpio};
    end else if (a == IO_BASE + 32'd4) begin
      if (w) e = 1'b1;
      else   rd = {24'h0, gi};
    end else e = 1'b1;
  endfunction

  // One transaction on the WAIT_CYCLES=2 instance; returns response and timing.
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic e, output int lat, output int width);
    int n;
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'($urandom);
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    lat = 1;
    while (bus.resp_valid !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    rd = bus.resp_rdata;
    e  = bus.resp_err;
    width = 0;
    while (bus.resp_valid === 1'b1 && width < 8) begin width++; @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus0.req_valid = 1'b0; bus0.req_write = 1'b0; bus0.req_addr = '0; bus0.req_wdata = '0;
    gin = 8'h00; gin0 = 8'h00;
    rst = 1'b0; rst0 = 1'b0;
    #2 rst = 1'b1; rst0 = 1'b1;
    #2;
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.req_ready); end
    checks++; if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0", bus.resp_valid); end
    checks++; if (bus.resp_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", bus.resp_rdata); end
    checks++; if (bus.resp_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus.resp_err); end
    checks++; if (gout !== 8'h00) begin failures++; $display("FAIL reset_gpio got=%h exp=00", gout); end
    checks++; if (gout0 !== 8'h00 || bus0.req_ready !== 1'b1) begin failures++; $display("FAIL reset_dut0 gpio=%h ready=%b exp 00/1", gout0, bus0.req_ready); end
    @(posedge clk); #1;
    rst = 1'b0; rst0 = 1'b0;
    mdl_gpio = 8'h00;
    @(posedge clk); #1;
  endtask

  task automatic preload;
    logic [31:0] rd, xr, d; logic e, xe; int lat, width;
    for (int i = 0; i < 256; i++) begin
      d = $urandom;
      model(1'b1, 32'(i * 4), d, gin, xr, xe);
      txn(1'b1, 32'(i * 4), d, rd, e, lat, width);
    end
  endtask

  task automatic test_basic;
    logic [31:0] rd, xr; logic e, xe; int lat, width;
    model(1'b1, 32'h10, 32'hDEAD_BEEF, gin, xr, xe);
    txn(1'b1, 32'h10, 32'hDEAD_BEEF, rd, e, lat, width);
    checks++; if (e !== 1'b0 || lat != 4 || width != 1) begin failures++; $display("FAIL basic_write err=%b lat=%0d width=%0d exp 0/4/1", e, lat, width); end
    model(1'b0, 32'h10, 32'h0, gin, xr, xe);
    txn(1'b0, 32'h10, 32'h0, rd, e, lat, width);
    checks++; if (rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL basic_read_data got=%h exp=deadbeef", rd); end
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL basic_read_err got=%b exp=0", e); end
    checks++; if (lat != 4 || width != 1) begin failures++; $display("FAIL basic_read_timing lat=%0d width=%0d exp 4/1", lat, width); end
  endtask

  task automatic test_zero_wait;
    int lat, lowc, respc; logic [31:0] rd; logic e;
    bus0.req_valid = 1'b1; bus0.req_write = 1'b1; bus0.req_addr = 32'h0; bus0.req_wdata = 32'h0000_0013;
    @(posedge clk); #1;
    bus0.req_valid = 1'b0;
    lat = 1;
    while (bus0.resp_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    checks++; if (lat != 2) begin failures++; $display("FAIL zw_write_lat got=%0d exp=2", lat); end
    @(posedge clk); #1;
    bus0.req_valid = 1'b1; bus0.req_write = 1'b0; bus0.req_addr = 32'h0;
    @(posedge clk); #1;
    bus0.req_valid = 1'b0;
    lowc = 0; respc = 0; rd = '0; e = 1'b1;
    while (bus0.req_ready !== 1'b1 && lowc < 20) begin
      lowc++;
      if (bus0.resp_valid === 1'b1) begin respc = lowc; rd = bus0.resp_rdata; e = bus0.resp_err; end
      @(posedge clk); #1;
    end
    checks++; if (lowc != 2) begin failures++; $display("FAIL zw_ready_low got=%0d exp=2", lowc); end
    checks++; if (respc != 2) begin failures++; $display("FAIL zw_resp_lat got=%0d exp=2", respc); end
    checks++; if (rd !== 32'h0000_0013 || e !== 1'b0) begin failures++; $display("FAIL zw_read got=%h/%b exp=00000013/0", rd, e); end
  endtask

  task automatic test_errors;
    logic [31:0] rd, xr, d; logic e, xe; int lat, width;
    model(1'b0, 32'h6, 32'h0, gin, xr, xe);
    txn(1'b0, 32'h6, 32'h0, rd, e, lat, width);
    checks++; if (e !== 1'b1 || rd !== 32'h0) begin failures++; $display("FAIL misaligned got=%h/%b exp=0/1", rd, e); end
    d = $urandom;
    model(1'b1, 32'h400, d, gin, xr, xe);
    txn(1'b1, 32'h400, d, rd, e, lat, width);
    checks++; if (e !== 1'b1 || rd !== 32'h0) begin failures++; $display("FAIL out_of_range got=%h/%b exp=0/1", rd, e); end
    model(1'b0, 32'h4, 32'h0, gin, xr, xe);
    txn(1'b0, 32'h4, 32'h0, rd, e, lat, width);
    checks++; if (rd !== xr || e !== 1'b0) begin failures++; $display("FAIL word1_intact got=%h exp=%h", rd, xr); end
    model(1'b0, 32'h0, 32'h0, gin, xr, xe);
    txn(1'b0, 32'h0, 32'h0, rd, e, lat, width);
    checks++; if (rd !== xr || e !== 1'b0) begin failures++; $display("FAIL word0_intact got=%h exp=%h", rd, xr); end
  endtask

  task automatic test_gpio;
    logic [31:0] rd, xr; logic e, xe; int lat, width;
    model(1'b1, IO_BASE, 32'h1234_56A5, gin, xr, xe);
    txn(1'b1, IO_BASE, 32'h1234_56A5, rd, e, lat, width);
    checks++; if (gout !== 8'hA5 || e !== 1'b0) begin failures++; $display("FAIL gpio_write got=%h/%b exp=a5/0", gout, e); end
    gin = 8'h3C;
    model(1'b0, IO_BASE + 32'd4, 32'h0, gin, xr, xe);
    txn(1'b0, IO_BASE + 32'd4, 32'h0, rd, e, lat, width);
    checks++; if (rd !== 32'h0000_003C || e !== 1'b0) begin failures++; $display("FAIL gpio_in_read got=%h/%b exp=0000003c/0", rd, e); end
    model(1'b1, IO_BASE + 32'd4, 32'h0000_00FF, gin, xr, xe);
    txn(1'b1, IO_BASE + 32'd4, 32'h0000_00FF, rd, e, lat, width);
    checks++; if (e !== 1'b1 || gout !== 8'hA5) begin failures++; $display("FAIL gpio_in_write err=%b gpio=%h exp 1/a5", e, gout); end
    model(1'b0, IO_BASE, 32'h0, gin, xr, xe);
    txn(1'b0, IO_BASE, 32'h0, rd, e, lat, width);
    checks++; if (rd !== 32'h0000_00A5) begin failures++; $display("FAIL gpio_out_read got=%h exp=000000a5", rd); end
  endtask

  task automatic test_reset_abort;
    logic [31:0] rd, xr; logic e, xe; int lat, width; logic seen;
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 32'h20; bus.req_wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #2 rst = 1'b0;
    mdl_gpio = 8'h00;
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL abort_ready got=%b exp=1", bus.req_ready); end
    seen = 1'b0;
    repeat (8) begin @(posedge clk); #1; if (bus.resp_valid !== 1'b0) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL abort_resp got=%b exp=0", seen); end
    checks++; if (gout !== 8'h00) begin failures++; $display("FAIL abort_gpio got=%h exp=00", gout); end
    model(1'b0, 32'h20, 32'h0, gin, xr, xe);
    txn(1'b0, 32'h20, 32'h0, rd, e, lat, width);
    checks++; if (rd !== xr) begin failures++; $display("FAIL abort_mem got=%h exp=%h", rd, xr); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] xr; logic xe; int lat;
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h40;
    @(posedge clk); #1;
    lat = 1;
    while (bus.resp_valid !== 1'b1 && lat < 40) begin
      bus.req_addr = {22'h0, 8'($urandom), 2'b00};
      @(posedge clk); #1;
      lat++;
    end
    model(1'b0, 32'h40, 32'h0, gin, xr, xe);
    checks++; if (bus.resp_rdata !== xr || lat != 4) begin failures++; $display("FAIL hold_first got=%h lat=%0d exp=%h lat=4", bus.resp_rdata, lat, xr); end
    checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL hold_ready_in_resp got=%b exp=0", bus.req_ready); end
    bus.req_addr = 32'h44;
    @(posedge clk); #1;
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL hold_ready_after got=%b exp=1", bus.req_ready); end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (bus.resp_valid !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    model(1'b0, 32'h44, 32'h0, gin, xr, xe);
    checks++; if (bus.resp_rdata !== xr || lat != 4) begin failures++; $display("FAIL hold_second got=%h lat=%0d exp=%h lat=4", bus.resp_rdata, lat, xr); end
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    logic [31:0] a, d, rd, xr; logic w, e, xe; int lat, width, kind;
    for (int i = 0; i < 60; i++) begin
      kind = int'($urandom_range(0, 9));
      case (kind)
        5:       a = 32'($urandom_range(0, 255) * 4 + $urandom_range(1, 3));
        6:       a = IO_BASE;
        7:       a = IO_BASE + 32'd4;
        8:       a = 32'h8000_0000 | $urandom;
        9:       a = ($urandom_range(0, 1) == 0) ? 32'd1020 : 32'd1024;
        default: a = 32'($urandom_range(0, 255) * 4);
      endcase
      w   = 1'($urandom);
      d   = $urandom;
      gin = 8'($urandom);
      model(w, a, d, gin, xr, xe);
      txn(w, a, d, rd, e, lat, width);
      checks++; if (rd !== xr) begin failures++; $display("FAIL rand_rdata[%0d] a=%h w=%b got=%h exp=%h", i, a, w, rd, xr); end
      checks++; if (e !== xe) begin failures++; $display("FAIL rand_err[%0d] a=%h got=%b exp=%b", i, a, e, xe); end
      checks++; if (lat != 4 || width != 1) begin failures++; $display("FAIL rand_timing[%0d] lat=%0d width=%0d exp 4/1", i, lat, width); end
      checks++; if (gout !== mdl_gpio) begin failures++; $display("FAIL rand_gpio[%0d] got=%h exp=%h", i, gout, mdl_gpio); end
    end
  endtask

  initial begin
    test_reset();
    preload();
    test_basic();
    test_zero_wait();
    test_errors();
    test_gpio();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
